// File: rtl/down_counter_underflow_if.sv
// down_counter_underflow_if: load handshake, control and status bundle for the countdown counter
interface down_counter_underflow_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             load_valid;
  logic [WIDTH-1:0] load_value;
  logic             load_ready;
  logic             clr_underflow;
  logic [WIDTH-1:0] counter_out;
  logic             zero_out;
  logic             done_out;
  logic             underflow_out;
  modport master (
    output enable, load_valid, load_value, clr_underflow,
    input  load_ready, counter_out, zero_out, done_out, underflow_out
  );
  modport slave (
    input  enable, load_valid, load_value, clr_underflow,
    output load_ready, counter_out, zero_out, done_out, underflow_out
  );
endinterface

// File: rtl/down_counter_underflow.sv
// down_counter_underflow: loadable down-counter with done pulse and sticky underflow; DOWN_COUNTER_AUTO_RELOAD_EN swaps the wrap for a reload
module down_counter_underflow #(
  parameter int WIDTH = 4
) (
  input logic                      clk,
  input logic                      reset,
  down_counter_underflow_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic             done_q, done_d;
  logic             underflow_q, underflow_d;
  logic             load_acc;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;
`endif
  assign bus.load_ready    = state_q != RUN;
  assign load_acc          = bus.load_valid && bus.load_ready;
  assign bus.counter_out   = counter_q;
  assign bus.zero_out      = counter_q == '0;
  assign bus.done_out      = done_q;
  assign bus.underflow_out = underflow_q;
  // next state: load first, then decrement in RUN, then wrap or reload from HALT
  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    done_d      = 1'b0;
    underflow_d = underflow_q & ~bus.clr_underflow;
    if (load_acc) begin
      counter_d = bus.load_value;
      state_d   = (bus.load_value != '0) ? RUN : IDLE;
    end else if (bus.enable && state_q == RUN) begin
      counter_d = counter_q - WIDTH'(1);
      done_d    = counter_q == WIDTH'(1);
      state_d   = (counter_q == WIDTH'(1)) ? HALT : RUN;
    end else if (bus.enable && state_q == HALT) begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      counter_d = reload_q;
      state_d   = (reload_q != '0) ? RUN : IDLE;
`else
      counter_d   = '1;
      underflow_d = 1'b1;
      state_d     = RUN;
`endif
    end
  end
  // state and registered outputs; reset overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      done_q      <= done_d;
      underflow_q <= underflow_d;
    end
  end
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  // reload value remembers the most recent accepted load
  always_ff @(posedge clk) begin
    if (reset) reload_q <= '0;
    else if (load_acc) reload_q <= bus.load_value;
  end
`endif
endmodule

// File: tb/tb_down_counter_underflow.sv
// tb_down_counter_underflow: directed checks of load, countdown, done, underflow/reload and reset
module tb_down_counter_underflow;
  localparam int WIDTH = 4;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  logic [WIDTH-1:0] e;
  down_counter_underflow_if #(.WIDTH(WIDTH)) bus ();
  down_counter_underflow #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_value = '0;
    bus.clr_underflow = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("rst_cnt", bus.counter_out, 0);
    check("rst_zero", bus.zero_out, 1);
    check("rst_ready", bus.load_ready, 1);
    check("rst_done", bus.done_out, 0);
    check("rst_uf", bus.underflow_out, 0);
    bus.load_valid = 1'b1;
    bus.load_value = 4'd3;
    step();
    check("ld3_cnt", bus.counter_out, 3);
    check("ld3_ready", bus.load_ready, 0);
    check("ld3_zero", bus.zero_out, 0);
    bus.load_valid = 1'b0;
    bus.enable = 1'b1;
    step();
    check("cd2_cnt", bus.counter_out, 2);
    check("cd2_done", bus.done_out, 0);
    step();
    check("cd1_cnt", bus.counter_out, 1);
    check("cd1_ready", bus.load_ready, 0);
    step();
    check("cd0_cnt", bus.counter_out, 0);
    check("cd0_done", bus.done_out, 1);
    check("cd0_ready", bus.load_ready, 1);
    check("cd0_zero", bus.zero_out, 1);
    bus.enable = 1'b0;
    step();
    check("halt_cnt", bus.counter_out, 0);
    check("halt_done_drop", bus.done_out, 0);
`ifndef DOWN_COUNTER_AUTO_RELOAD_EN
    bus.enable = 1'b1;
    step();
    check("wrap_cnt", bus.counter_out, 15);
    check("wrap_uf", bus.underflow_out, 1);
    check("wrap_ready", bus.load_ready, 0);
    bus.enable = 1'b0;
    step();
    check("uf_hold", bus.underflow_out, 1);
    check("hold_cnt", bus.counter_out, 15);
    bus.clr_underflow = 1'b1;
    step();
    check("uf_clr", bus.underflow_out, 0);
    bus.clr_underflow = 1'b0;
    bus.enable = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check("run15_cnt", bus.counter_out, 0);
    check("run15_done", bus.done_out, 1);
    bus.clr_underflow = 1'b1;
    step();
    check("setclr_cnt", bus.counter_out, 15);
    check("setclr_uf", bus.underflow_out, 1);
    bus.clr_underflow = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("at5_cnt", bus.counter_out, 5);
    bus.enable = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_value = 4'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ignld_cnt", bus.counter_out, 5);
      check("ignld_ready", bus.load_ready, 0);
    end
    bus.load_valid = 1'b0;
`else
    bus.enable = 1'b1;
    step();
    check("rl_cnt", bus.counter_out, 3);
    check("rl_uf", bus.underflow_out, 0);
    check("rl_ready", bus.load_ready, 0);
    bus.enable = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_value = 4'd2;
    step();
    check("ld2_cnt", bus.counter_out, 2);
    bus.load_valid = 1'b0;
    bus.enable = 1'b1;
    e = 4'd2;
    for (int i = 0; i < 9; i++) begin
      step();
      e = (e == 0) ? 4'd2 : e - 4'd1;
      check("ar_cnt", bus.counter_out, e);
      check("ar_done", bus.done_out, e == 0);
      check("ar_uf", bus.underflow_out, 0);
    end
    bus.enable = 1'b0;
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_value = 4'd1;
    step();
    bus.load_valid = 1'b0;
    bus.enable = 1'b1;
    step();
    check("h1_cnt", bus.counter_out, 0);
    check("h1_done", bus.done_out, 1);
    bus.load_valid = 1'b1;
    bus.load_value = 4'd5;
    step();
    check("ldwin_cnt", bus.counter_out, 5);
    check("ldwin_ready", bus.load_ready, 0);
    check("ldwin_uf", bus.underflow_out, 0);
    check("ldwin_done", bus.done_out, 0);
    bus.load_valid = 1'b0;
    bus.enable = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_value = 4'd7;
    step();
    bus.load_valid = 1'b0;
    bus.enable = 1'b1;
    step();
    check("at6_cnt", bus.counter_out, 6);
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.enable = 1'b0;
    check("midrst_cnt", bus.counter_out, 0);
    check("midrst_ready", bus.load_ready, 1);
    check("midrst_done", bus.done_out, 0);
    bus.load_valid = 1'b1;
    bus.load_value = 4'd0;
    step();
    check("ld0_cnt", bus.counter_out, 0);
    check("ld0_ready", bus.load_ready, 1);
    check("ld0_done", bus.done_out, 0);
    bus.load_valid = 1'b0;
    bus.enable = 1'b1;
    step();
    check("idle_en_cnt", bus.counter_out, 0);
    check("idle_en_uf", bus.underflow_out, 0);
    check("idle_en_ready", bus.load_ready, 1);
    bus.enable = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
